// File: rtl/iobuf_dir_arbiter_pkg.sv
// Shared definitions for the pad-bus direction arbiter: FSM state encoding,
// bus direction constants and the op-to-direction mapping.
package iobuf_dir_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic DIR_DRIVE    = 1'b1;
  localparam logic DIR_RELEASED = 1'b0;

  // A write needs the bus driven, a read needs it released.
  function automatic logic op_dir(input logic we);
    return we ? DIR_DRIVE : DIR_RELEASED;
  endfunction

endpackage

// File: rtl/iobuf_dir_arbiter_rr_arb.sv
// Two-way round-robin arbiter; LAST remembers the most recent winner and
// resets to 1 so requester 0 wins the first contended round.
module iobuf_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       valid_o,
  output logic       win_o
);

  logic last_q, last_d;

  always_comb begin
    valid_o = |req_i;
    win_o   = (&req_i) ? ~last_q : req_i[1];
    last_d  = (take_i && valid_o) ? win_o : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/iobuf_dir_arbiter.sv
// Pad-bus arbiter: grants one of two requesters, inserts turnaround cycles on
// direction changes, sequences reads. Bus parking selected by IOBUF_ARB_PARK_EN.
module iobuf_dir_arbiter
  import iobuf_dir_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic [WIDTH-1:0] WD0,
  input  logic [WIDTH-1:0] WD1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [WIDTH-1:0] RD,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic [WIDTH-1:0] PAD_O
);

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
  localparam logic [3:0] READ_LAST = 4'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             win_q, win_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;
  logic             rd_cap;

  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] pad_i_q, pad_i_d;
  logic             pad_t_q, pad_t_d;
  logic             park;

  logic [1:0]       req_live;
  logic             arb_valid, arb_win, arb_take;

  assign req_live = {REQ1, REQ0} & ~ack_q;
  assign arb_take = (state_q == IDLE);

  iobuf_rr_arb u_rr_arb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .req_i   (req_live),
    .take_i  (arb_take),
    .valid_o (arb_valid),
    .win_o   (arb_win)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner's op and write data are latched at grant so a dropped REQ cannot
  // disturb the transaction in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    win_d   = win_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rd_cap  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d  = arb_win;
          we_d   = arb_win ? WE1 : WE0;
          wdat_d = arb_win ? WD1 : WD0;
          cnt_d  = '0;
          if (op_dir(we_d) != dir_q) begin
            state_d = TURN;
          end else begin
            state_d = we_d ? WRITE : READ;
          end
        end
      end
      TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          dir_d   = op_dir(we_q);
          state_d = we_q ? WRITE : READ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE: state_d = DONE;
      READ: begin
        if (cnt_q == READ_LAST) begin
          cnt_d   = '0;
          rd_cap  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered.
  always_comb begin
`ifdef IOBUF_ARB_PARK_EN
    park = ((state_d == IDLE) || (state_d == DONE)) && (dir_d == DIR_DRIVE);
`else
    park = 1'b0;
`endif
    gnt_d   = (state_d != IDLE) ? (win_d ? 2'b10 : 2'b01) : '0;
    ack_d   = (state_d == DONE) ? (win_d ? 2'b10 : 2'b01) : '0;
    pad_i_d = (state_d == WRITE) ? wdat_d : pad_i_q;
    pad_t_d = ~((state_d == WRITE) || park);
    rd_d    = rd_cap ? PAD_O : rd_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      dir_q   <= DIR_RELEASED;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rd_q    <= '0;
      pad_i_q <= '0;
      pad_t_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      pad_i_q <= pad_i_d;
      pad_t_q <= pad_t_d;
    end
  end

  assign GNT0  = gnt_q[0];
  assign GNT1  = gnt_q[1];
  assign ACK0  = ack_q[0];
  assign ACK1  = ack_q[1];
  assign RD    = rd_q;
  assign PAD_I = pad_i_q;
  assign PAD_T = pad_t_q;

endmodule

// File: tb/tb_iobuf_dir_arbiter.sv
// Randomized bench for iobuf_dir_arbiter against a transaction-level timing model.
// Honours IOBUF_ARB_PARK_EN when predicting PAD_T.
module tb_iobuf_dir_arbiter;

  localparam int W    = 8;
  localparam int TC   = 1;
  localparam int RL   = 2;
  localparam int NCYC = 900;
`ifdef IOBUF_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [W-1:0] wd0, wd1, pad_o;
  logic         gnt0, gnt1, ack0, ack1, pad_t;
  logic [W-1:0] rd, pad_i;

  iobuf_dir_arbiter #(.WIDTH(W), .TURN_CYC(TC), .RD_LAT(RL)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1), .WD0(wd0), .WD1(wd1),
    .GNT0(gnt0), .GNT1(gnt1), .ACK0(ack0), .ACK1(ack1),
    .RD(rd), .PAD_I(pad_i), .PAD_T(pad_t), .PAD_O(pad_o)
  );

  always #5 clk = ~clk;

  int unsigned n_tests, n_fail;
  int          e_now;
  logic [W-1:0] pad_tab [NCYC+64];

  // Requester side
  logic         rq [2];
  logic         rwe [2];
  logic [W-1:0] rwd [2];

  // Transaction-level model: one transaction with its scheduled intervals
  bit           busy, m_we, m_win, m_last, m_dir, parked;
  int           m_n, m_t, m_ack;
  logic [W-1:0] m_data, m_pad_i, m_rd, m_rdv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s interval %0d: got %0h expected %0h", tag, e_now, got, exp);
    end
  endtask

  task automatic model_reset();
    busy = 0; m_last = 1; m_dir = 0; parked = 0;
    m_pad_i = '0; m_rd = '0;
  endtask

  task automatic drive();
    req0 = rq[0]; req1 = rq[1];
    we0 = rwe[0]; we1 = rwe[1];
    wd0 = rwd[0]; wd1 = rwd[1];
  endtask

  task automatic check_interval();
    int  e;
    bit  inwin, eg0, eg1, ea0, ea1, ept;
    e     = e_now;
    inwin = busy && (e >= m_n) && (e <= m_ack);
    if (busy && m_we && e == m_n + m_t) begin
      m_pad_i = m_data;
      parked  = 1;
    end
    if (busy && !m_we && e == m_ack) m_rd = m_rdv;
    eg0 = inwin && !m_win;
    eg1 = inwin && m_win;
    ea0 = busy && (e == m_ack) && !m_win;
    ea1 = busy && (e == m_ack) && m_win;
    ept = (PARK && parked) ? 1'b0 : 1'b1;
    if (inwin && !m_we) ept = 1'b1;
    if (inwin && m_we && e < m_n + m_t) ept = 1'b1;
    if (busy && m_we && e == m_n + m_t) ept = 1'b0;
    chk("gnt0",  32'(gnt0),  32'(eg0));
    chk("gnt1",  32'(gnt1),  32'(eg1));
    chk("ack0",  32'(ack0),  32'(ea0));
    chk("ack1",  32'(ack1),  32'(ea1));
    chk("pad_t", 32'(pad_t), 32'(ept));
    chk("pad_i", 32'(pad_i), 32'(m_pad_i));
    chk("rd",    32'(rd),    32'(m_rd));
  endtask

  task automatic stimulus(input int c);
    for (int i = 0; i < 2; i++) begin
      if (busy && e_now == m_ack && int'(m_win) == i) begin
        rq[i] = 0;
      end else if (c < 450 && rq[i] && busy && int'(m_win) == i &&
                   e_now >= m_n && e_now < m_ack && $urandom_range(15) == 0) begin
        rq[i] = 0; rwe[i] = 1'($urandom); rwd[i] = W'($urandom);
      end
      if (!rq[i]) begin
        if (c < 450) begin
          if ($urandom_range(2) == 0) begin
            rq[i] = 1; rwe[i] = 1'($urandom); rwd[i] = W'($urandom);
          end
        end else if (c < 650) begin
          rq[i] = 1; rwe[i] = 1; rwd[i] = W'($urandom);
        end else if (i == 0) begin
          rq[i] = 1; rwe[i] = 0; rwd[i] = W'($urandom);
        end
      end
    end
    if (c > 5 && c < 450 && $urandom_range(39) == 0) rst = 1;
  endtask

  // Decide the grant taken at the coming edge (interval e_now+1).
  task automatic arbitrate();
    bit w;
    if (!busy || e_now >= m_ack + 1) begin
      busy = 0;
      if (rq[0] || rq[1]) begin
        w      = (rq[0] && rq[1]) ? !m_last : rq[1];
        m_last = w;
        m_win  = w;
        m_we   = rwe[w];
        m_data = rwd[w];
        m_t    = (m_we != m_dir) ? TC : 0;
        m_dir  = m_we;
        m_n    = e_now + 1;
        m_ack  = m_we ? (m_n + m_t + 1) : (m_n + m_t + RL);
        if (!m_we) begin
          m_rdv  = pad_tab[m_ack-1];
          parked = 0;
        end
        busy = 1;
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    for (int k = 0; k < NCYC + 64; k++) pad_tab[k] = W'($urandom);
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; rwe[i] = 0; rwd[i] = '0;
    end
    pad_o = '0;
    drive();
    model_reset();
    e_now = 0;
    @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      check_interval();
      rst = 0;
      stimulus(c);
      if (rst) model_reset();
      else arbitrate();
      pad_o = pad_tab[e_now];
      drive();
      e_now++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iobuf_dir_arbiter.md
IOBUF_DIR_ARBITER -- requirements
Module: iobuf_dir_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pad bus width in bits.
REQ-002 SHALL have parameter TURN_CYC, default 1, number of bus-idle cycles (PAD_T=1) inserted on every direction change; legal range 1..15.
REQ-003 SHALL have parameter RD_LAT, default 2, number of released-bus cycles before PAD_O is captured; legal range 1..15.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 REQ0, REQ1  input  1  request from requester 0 and requester 1; held high until ACK.
REQ-007 WE0, WE1  input  1  1 = write (drive pad), 0 = read (sample pad); stable while REQ is high.
REQ-008 WD0, WD1  input  WIDTH  write data; stable while REQ is high.
REQ-009 GNT0, GNT1  output  1  grant; high from the first cycle after arbitration through the ACK cycle inclusive.
REQ-010 ACK0, ACK1  output  1  one-cycle completion pulse.
REQ-011 RD  output  WIDTH  read data; valid with ACK of a read; holds until the next read capture.
REQ-012 PAD_I  output  WIDTH  to tri-state buffer data input.
REQ-013 PAD_T  output  1  to tri-state buffer enable; 1 = high-Z, 0 = drive.
REQ-014 PAD_O  input  WIDTH  from pad input buffer.

Function
REQ-015 SHALL implement states IDLE, TURN, WRITE, READ, DONE; all outputs registered.
REQ-016 IDLE: if any REQ is high (excluding a requester being ACKed this cycle), SHALL select a winner, assert its GNT next cycle, and go to TURN if its op direction differs from register DIR, else directly to WRITE or READ.
REQ-017 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; LAST resets to 1 so requester 0 wins first.
REQ-018 TURN: PAD_T=1 for exactly TURN_CYC cycles, then WRITE or READ; DIR updated on exit.
REQ-019 WRITE: exactly one cycle, PAD_T=0, PAD_I=winner's WD; then DONE.
REQ-020 READ: PAD_T=1 for RD_LAT cycles; on the last cycle's edge RD SHALL capture PAD_O; then DONE.
REQ-021 DONE: one cycle, ACK of winner high, GNT still high; next state IDLE.
REQ-022 Latency (same direction, REQ seen in IDLE at edge n): write ACK at cycle n+2; read ACK at n+RD_LAT+1; add TURN_CYC on direction change.
REQ-023 REQ deasserted while granted SHALL be ignored; the transaction completes and ACKs.
REQ-024 Outside WRITE (and parking, REQ-029), PAD_T SHALL be 1; PAD_I SHALL hold last written value.
REQ-025 PAD_T=0 and a read capture SHALL never occur without TURN_CYC idle cycles between them in either order.

Reset
REQ-026 On RST, next edge: state IDLE, PAD_T=1, PAD_I=0, RD=0, GNT*=0, ACK*=0, DIR=released, LAST=1, counters 0.
REQ-027 RST mid-transaction SHALL abort it with no ACK; requester re-requests.

Configuration
REQ-028 Macro IOBUF_ARB_PARK_EN SHALL select bus parking.
REQ-029 With IOBUF_ARB_PARK_EN defined: after a write, IDLE keeps PAD_T=0 driving last PAD_I until a read wins (which then takes TURN) or RST. Without it: PAD_T=1 in IDLE always.

Structure
REQ-030 Shared package SHALL hold the state encoding enum and DIR encoding constants (DIR_DRIVE, DIR_RELEASED).
REQ-031 One sub-module iobuf_rr_arb (two-way round-robin with LAST register) SHALL be used; FSM, counter and datapath in top.

Verification
REQ-032 Reset then REQ0 write WD0=8'hA5 -> TURN 1 cycle, PAD_T=0 with PAD_I=8'hA5 for one cycle, ACK0 one cycle after.
REQ-033 After that write, REQ1 read, PAD_O=8'h3C -> TURN_CYC=1 idle cycle, RD=8'h3C with ACK1 at RD_LAT+1 after TURN exit.
REQ-034 REQ0 and REQ1 high continuously, both writes -> grants alternate 0,1,0,1; no back-to-back ACK to same requester.
REQ-035 Two consecutive reads by REQ0 -> no TURN between them; second ACK RD_LAT+2 cycles after first.
REQ-036 RST asserted during WRITE -> next cycle PAD_T=1, GNT0=0, no ACK0.
REQ-037 IOBUF_ARB_PARK_EN defined, write 8'h11 then idle 5 cycles -> PAD_T stays 0, PAD_I=8'h11; subsequent read inserts TURN.
